// File: rtl/lsu_ecc_scrub.sv
// lsu_ecc_scrub
//   Multi-bank SEC-DED check, correction and scrub stage for the DCCM read
//   path. Each enabled bank word is decoded combinationally. Corrected data
//   and per-bank error flags are registered, so they appear one cycle after
//   the read. Every corrected single-bit error is queued as a write-back
//   request toward the DCCM write arbiter. Saturating error counters are kept
//   for the TLU.
//
//   Code: extended Hamming. Check bit k (k < ECC_WIDTH-1) sits at codeword
//   position 2^k. Data bits fill the remaining positions in ascending order,
//   starting at position 3. The top check bit is overall parity over data
//   and the other check bits. For DATA_WIDTH=32 this matches rvecc encode.
//
// Ports
//   clk, rst          core clock, synchronous active-high reset
//   rd_valid          read data valid this cycle
//   rd_addr           row address of the read
//   rd_bank_en        banks participating in the read
//   rd_data, rd_ecc   raw bank words and stored check bits, bank b at slice b
//   ecc_disable       bypass: raw data, no flags, no counts, no pushes
//   detect_only       flag errors, but do not correct or enqueue
//   out_valid         registered rd_valid
//   out_data          registered corrected (or raw) data
//   single_err        registered correctable-error flag per bank
//   double_err        registered uncorrectable-error flag per bank
//   any_single        OR-reduction of single_err
//   any_double        OR-reduction of double_err
//   scrub_*           scrub queue head (valid/ready), ecc re-encoded from data
//   scrub_overflow    sticky: at least one scrub push was dropped
//   single_cnt        saturating count of correctable errors
//   double_cnt        saturating count of uncorrectable errors
//   cnt_clr           clear counters and scrub_overflow
//
// Scrub handshake: an entry transfers on any rising edge where
// scrub_valid & scrub_ready are both high. scrub_valid never depends on
// scrub_ready. While scrub_valid is high and scrub_ready is low, the head
// entry and every scrub_* output hold steady. New pushes go to the tail only.
module lsu_ecc_scrub #(
    parameter int NUM_BANKS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ECC_WIDTH  = 7,
    parameter int ADDR_WIDTH = 16,
    parameter int QDEPTH     = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int BANK_W    = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            rd_valid,
    input  logic [ADDR_WIDTH-1:0]           rd_addr,
    input  logic [NUM_BANKS-1:0]            rd_bank_en,
    input  logic [NUM_BANKS*DATA_WIDTH-1:0] rd_data,
    input  logic [NUM_BANKS*ECC_WIDTH-1:0]  rd_ecc,
    input  logic                            ecc_disable,
    input  logic                            detect_only,
    output logic                            out_valid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0] out_data,
    output logic [NUM_BANKS-1:0]            single_err,
    output logic [NUM_BANKS-1:0]            double_err,
    output logic                            any_single,
    output logic                            any_double,
    output logic                            scrub_valid,
    input  logic                            scrub_ready,
    output logic [ADDR_WIDTH-1:0]           scrub_addr,
    output logic [BANK_W-1:0]               scrub_bank,
    output logic [DATA_WIDTH-1:0]           scrub_data,
    output logic [ECC_WIDTH-1:0]            scrub_ecc,
    output logic                            scrub_overflow,
    output logic [CNT_WIDTH-1:0]            single_cnt,
    output logic [CNT_WIDTH-1:0]            double_cnt,
    input  logic                            cnt_clr
);

    localparam int P      = ECC_WIDTH - 1;       // Hamming check bits, excluding overall parity
    localparam int CW_LEN = DATA_WIDTH + P;      // highest valid codeword position
    localparam int QW     = $clog2(QDEPTH);
    localparam int SUMW   = CNT_WIDTH + 4;       // headroom for adding up to 8 flags

    localparam logic [P-1:0]         CW_LAST = P'(CW_LEN);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [QW:0]          Q_FULL  = (QW + 1)'(QDEPTH);

    // Return the codeword position of each data bit (all non-power-of-two positions).
    function automatic logic [DATA_WIDTH-1:0][P-1:0] build_pos();
        logic [DATA_WIDTH-1:0][P-1:0] t;
        int n;
        t = '0;
        n = 0;
        for (int p = 3; p <= CW_LEN; p++) begin
            if (((p & (p - 1)) != 0) && (n < DATA_WIDTH)) begin
                t[n] = P'(p);
                n    = n + 1;
            end
        end
        return t;
    endfunction

    // Select, for each check bit k, the data bits whose position has bit k set.
    function automatic logic [P-1:0][DATA_WIDTH-1:0] build_masks(
        input logic [DATA_WIDTH-1:0][P-1:0] pos
    );
        logic [P-1:0][DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            for (int k = 0; k < P; k++) begin
                m[k][i] = pos[i][k];
            end
        end
        return m;
    endfunction

    localparam logic [DATA_WIDTH-1:0][P-1:0] DATA_POS = build_pos();
    localparam logic [P-1:0][DATA_WIDTH-1:0] CHK_MASK = build_masks(DATA_POS);

    function automatic logic [P-1:0] check_bits(input logic [DATA_WIDTH-1:0] d);
        logic [P-1:0] c;
        for (int k = 0; k < P; k++) begin
            c[k] = ^(d & CHK_MASK[k]);
        end
        return c;
    endfunction

    function automatic logic [ECC_WIDTH-1:0] ecc_encode(input logic [DATA_WIDTH-1:0] d);
        logic [P-1:0] c;
        c = check_bits(d);
        return {(^d) ^ (^c), c};
    endfunction

    // ---------------------------------------------------------------- decode
    logic [NUM_BANKS*DATA_WIDTH-1:0] data_d;
    logic [NUM_BANKS-1:0]            sgl_d;
    logic [NUM_BANKS-1:0]            dbl_d;
    logic [NUM_BANKS-1:0]            push_d;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] raw;
        logic [DATA_WIDTH-1:0] fixed;
        logic [ECC_WIDTH-1:0]  ecc_in;
        logic [P-1:0]          syn;
        logic                  chk;
        logic                  pm;
        logic                  in_range;
        logic                  sgl;

        assign raw      = rd_data[b*DATA_WIDTH +: DATA_WIDTH];
        assign ecc_in   = rd_ecc[b*ECC_WIDTH +: ECC_WIDTH];
        assign syn      = ecc_in[P-1:0] ^ check_bits(raw);
        assign pm       = (^raw) ^ (^ecc_in);
        assign in_range = (syn <= CW_LAST);
        assign chk      = rd_valid & rd_bank_en[b] & ~ecc_disable;

        // A parity mismatch with a zero syndrome is an error in the parity bit
        // itself. It still counts as single, and the data is left unchanged.
        assign sgl       = chk & pm & in_range;
        assign sgl_d[b]  = sgl;
        assign dbl_d[b]  = chk & (syn != '0) & (~pm | ~in_range);
        assign push_d[b] = sgl & ~detect_only;

        // A syndrome that points at a check-bit position matches no data bit.
        always_comb begin
            fixed = raw;
            for (int i = 0; i < DATA_WIDTH; i++) begin
                if (syn == DATA_POS[i]) begin
                    fixed[i] = ~raw[i];
                end
            end
        end

        assign data_d[b*DATA_WIDTH +: DATA_WIDTH] = push_d[b] ? fixed : raw;
    end

    // ----------------------------------------------------------- scrub queue
    logic [ADDR_WIDTH-1:0] q_addr [QDEPTH];
    logic [BANK_W-1:0]     q_bank [QDEPTH];
    logic [DATA_WIDTH-1:0] q_data [QDEPTH];
    logic [QW-1:0]         rd_ptr;
    logic [QW-1:0]         wr_ptr;
    logic [QW:0]           q_count;
    logic [QW:0]           free_slots;
    logic [QW:0]           n_acc;
    logic [NUM_BANKS-1:0]  acc;
    logic [QW-1:0]         slot [NUM_BANKS];
    logic                  drop;
    logic                  pop;

    assign scrub_valid = (q_count != '0);
    assign pop         = scrub_valid & scrub_ready;

    // Free space is measured before this cycle's pop, so a same-cycle pop
    // never makes room for a push.
    always_comb begin
        free_slots = Q_FULL - q_count;
        n_acc      = '0;
        drop       = 1'b0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            acc[b]  = 1'b0;
            slot[b] = '0;
            if (push_d[b]) begin
                if (n_acc < free_slots) begin
                    acc[b]  = 1'b1;
                    slot[b] = wr_ptr + n_acc[QW-1:0];
                    n_acc   = n_acc + (QW + 1)'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (acc[b]) begin
                q_addr[slot[b]] <= rd_addr;
                q_bank[slot[b]] <= BANK_W'(b);
                q_data[slot[b]] <= data_d[b*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            q_count <= '0;
        end else begin
            rd_ptr  <= rd_ptr + QW'(pop);
            wr_ptr  <= wr_ptr + n_acc[QW-1:0];
            q_count <= q_count + n_acc - (QW + 1)'(pop);
        end
    end

    assign scrub_addr = scrub_valid ? q_addr[rd_ptr] : '0;
    assign scrub_bank = scrub_valid ? q_bank[rd_ptr] : '0;
    assign scrub_data = scrub_valid ? q_data[rd_ptr] : '0;
    assign scrub_ecc  = ecc_encode(scrub_data);

    // -------------------------------------------------------------- counters
    logic [SUMW-1:0]      s_sum;
    logic [SUMW-1:0]      d_sum;
    logic [CNT_WIDTH-1:0] s_next;
    logic [CNT_WIDTH-1:0] d_next;

    always_comb begin
        s_sum  = SUMW'(single_cnt) + SUMW'($countones(sgl_d));
        d_sum  = SUMW'(double_cnt) + SUMW'($countones(dbl_d));
        s_next = (s_sum > SUMW'(CNT_MAX)) ? CNT_MAX : s_sum[CNT_WIDTH-1:0];
        d_next = (d_sum > SUMW'(CNT_MAX)) ? CNT_MAX : d_sum[CNT_WIDTH-1:0];
    end

    // ---------------------------------------------------- registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_data       <= '0;
            single_err     <= '0;
            double_err     <= '0;
            any_single     <= 1'b0;
            any_double     <= 1'b0;
            single_cnt     <= '0;
            double_cnt     <= '0;
            scrub_overflow <= 1'b0;
        end else begin
            out_valid  <= rd_valid;
            out_data   <= data_d;
            single_err <= sgl_d;
            double_err <= dbl_d;
            any_single <= |sgl_d;
            any_double <= |dbl_d;
            // Clearing wins: increments and drops from the same cycle are lost.
            if (cnt_clr) begin
                single_cnt     <= '0;
                double_cnt     <= '0;
                scrub_overflow <= 1'b0;
            end else begin
                single_cnt <= s_next;
                double_cnt <= d_next;
                if (drop) begin
                    scrub_overflow <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_ecc_scrub.sv
// Bench for lsu_ecc_scrub: NUM_BANKS=2, DATA_WIDTH=32, QDEPTH=4, CNT_WIDTH=2.
// A behavioural model tracks codewords as position lists, the scrub queue as
// a SystemVerilog queue and the counters as plain integers.
module tb_lsu_ecc_scrub;

  localparam int NB = 2;
  localparam int DW = 32;
  localparam int EW = 7;
  localparam int AW = 16;
  localparam int QD = 4;
  localparam int CW = 2;

  logic            clk;
  logic            rst;
  logic            rd_valid;
  logic [AW-1:0]   rd_addr;
  logic [NB-1:0]   rd_bank_en;
  logic [NB*DW-1:0] rd_data;
  logic [NB*EW-1:0] rd_ecc;
  logic            ecc_disable;
  logic            detect_only;
  logic            out_valid;
  logic [NB*DW-1:0] out_data;
  logic [NB-1:0]   single_err;
  logic [NB-1:0]   double_err;
  logic            any_single;
  logic            any_double;
  logic            scrub_valid;
  logic            scrub_ready;
  logic [AW-1:0]   scrub_addr;
  logic [0:0]      scrub_bank;
  logic [DW-1:0]   scrub_data;
  logic [EW-1:0]   scrub_ecc;
  logic            scrub_overflow;
  logic [CW-1:0]   single_cnt;
  logic [CW-1:0]   double_cnt;
  logic            cnt_clr;

  lsu_ecc_scrub #(
    .NUM_BANKS(NB), .DATA_WIDTH(DW), .ECC_WIDTH(EW),
    .ADDR_WIDTH(AW), .QDEPTH(QD), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_bank_en(rd_bank_en),
    .rd_data(rd_data), .rd_ecc(rd_ecc),
    .ecc_disable(ecc_disable), .detect_only(detect_only),
    .out_valid(out_valid), .out_data(out_data),
    .single_err(single_err), .double_err(double_err),
    .any_single(any_single), .any_double(any_double),
    .scrub_valid(scrub_valid), .scrub_ready(scrub_ready),
    .scrub_addr(scrub_addr), .scrub_bank(scrub_bank),
    .scrub_data(scrub_data), .scrub_ecc(scrub_ecc),
    .scrub_overflow(scrub_overflow),
    .single_cnt(single_cnt), .double_cnt(double_cnt),
    .cnt_clr(cnt_clr)
  );

  // ------------------------------------------------------- clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic started;
  initial begin
    started = 1'b0;
    @(posedge clk);
    #1 started = 1'b1;
  end

  // ------------------------------------------------------- check bookkeeping
  int n_pass;
  int n_total;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total = n_total + 1;
    if (act === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // ------------------------------------------------------- reference model
  // Codeword position of data bit idx: the idx-th position 1..38 that is not a power of two.
  function automatic int dpos(input int idx);
    int n;
    n = 0;
    for (int p = 1; p <= DW + EW - 1; p++) begin
      if ($countones(p) != 1) begin
        if (n == idx) return p;
        n = n + 1;
      end
    end
    return 0;
  endfunction

  // Check bits are chosen so that the XOR of the positions of all one bits is zero.
  function automatic logic [EW-1:0] m_encode(input logic [DW-1:0] d);
    int s;
    logic [EW-1:0] e;
    s = 0;
    for (int i = 0; i < DW; i++) if (d[i]) s = s ^ dpos(i);
    e[5:0] = s[5:0];
    e[6] = (^d) ^ (^e[5:0]);
    return e;
  endfunction

  function automatic void m_decode(input logic [DW-1:0] d, input logic [EW-1:0] e,
                                   output logic sg, output logic db, output logic [DW-1:0] fx);
    int s;
    logic par;
    s = 0;
    for (int i = 0; i < DW; i++) if (d[i]) s = s ^ dpos(i);
    for (int k = 0; k < 6; k++) if (e[k]) s = s ^ (1 << k);
    par = (^d) ^ (^e);
    fx = d;
    sg = 1'b0;
    db = 1'b0;
    if (par) begin
      if (s > DW + EW - 1) db = 1'b1;
      else begin
        sg = 1'b1;
        for (int i = 0; i < DW; i++) if (dpos(i) == s) fx[i] = ~fx[i];
      end
    end else if (s != 0) begin
      db = 1'b1;
    end
  endfunction

  // Scoreboard entry: {addr[15:0], bank[0], data[31:0]}
  logic [48:0]     exp_q[$];
  logic            m_out_valid;
  logic [NB*DW-1:0] m_out_data;
  logic [NB-1:0]   m_sgl;
  logic [NB-1:0]   m_dbl;
  int              m_scnt;
  int              m_dcnt;
  logic            m_ovf;

  always @(posedge clk) begin : model
    logic sg;
    logic db;
    logic [DW-1:0] raw;
    logic [DW-1:0] fx;
    int free;
    int acc;
    int ns;
    int nd;
    if (rst) begin
      m_out_valid = 1'b0;
      m_out_data  = '0;
      m_sgl       = '0;
      m_dbl       = '0;
      m_scnt      = 0;
      m_dcnt      = 0;
      m_ovf       = 1'b0;
      exp_q.delete();
    end else begin
      free = QD - exp_q.size();
      acc = 0;
      ns = 0;
      nd = 0;
      m_out_valid = rd_valid;
      if (exp_q.size() > 0 && scrub_ready) void'(exp_q.pop_front());
      for (int b = 0; b < NB; b++) begin
        raw = rd_data[b*DW +: DW];
        m_decode(raw, rd_ecc[b*EW +: EW], sg, db, fx);
        if (!(rd_valid && rd_bank_en[b] && !ecc_disable)) begin
          sg = 1'b0;
          db = 1'b0;
        end
        m_sgl[b] = sg;
        m_dbl[b] = db;
        ns = ns + int'(sg);
        nd = nd + int'(db);
        if (sg && !detect_only) begin
          m_out_data[b*DW +: DW] = fx;
          if (acc < free) begin
            exp_q.push_back({rd_addr, 1'(b), fx});
            acc = acc + 1;
          end else begin
            m_ovf = 1'b1;
          end
        end else begin
          m_out_data[b*DW +: DW] = raw;
        end
      end
      if (cnt_clr) begin
        m_scnt = 0;
        m_dcnt = 0;
        m_ovf  = 1'b0;
      end else begin
        m_scnt = (m_scnt + ns > 3) ? 3 : m_scnt + ns;
        m_dcnt = (m_dcnt + nd > 3) ? 3 : m_dcnt + nd;
      end
    end
  end

  // ------------------------------------------------------- compare process
  always @(negedge clk) begin : cmp
    logic [48:0] h;
    if (started) begin
      check("out_valid", 64'(out_valid), 64'(m_out_valid));
      if (m_out_valid) check("out_data", 64'(out_data), 64'(m_out_data));
      check("single_err", 64'(single_err), 64'(m_sgl));
      check("double_err", 64'(double_err), 64'(m_dbl));
      check("any_single", 64'(any_single), 64'(|m_sgl));
      check("any_double", 64'(any_double), 64'(|m_dbl));
      check("scrub_valid", 64'(scrub_valid), 64'(exp_q.size() != 0));
      h = (exp_q.size() != 0) ? exp_q[0] : '0;
      check("scrub_addr", 64'(scrub_addr), 64'(h[48:33]));
      check("scrub_bank", 64'(scrub_bank), 64'(h[32]));
      check("scrub_data", 64'(scrub_data), 64'(h[31:0]));
      check("scrub_ecc", 64'(scrub_ecc), 64'(m_encode(h[31:0])));
      check("scrub_overflow", 64'(scrub_overflow), 64'(m_ovf));
      check("single_cnt", 64'(single_cnt), 64'(m_scnt));
      check("double_cnt", 64'(double_cnt), 64'(m_dcnt));
    end
  end

  // ------------------------------------------------------- driver tasks
  task automatic drive_read(input logic [AW-1:0] a, input logic [NB-1:0] en,
                            input logic [DW-1:0] d0, input logic [EW-1:0] e0,
                            input logic [DW-1:0] d1, input logic [EW-1:0] e1);
    rd_valid   = 1'b1;
    rd_addr    = a;
    rd_bank_en = en;
    rd_data    = {d1, d0};
    rd_ecc     = {e1, e0};
    @(negedge clk);
    rd_valid   = 1'b0;
  endtask

  task automatic idle(input int n);
    rd_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic make_word(output logic [DW-1:0] d, output logic [EW-1:0] e);
    logic [DW+EW-1:0] cw;
    int a;
    int c;
    int mode;
    d = $urandom;
    e = m_encode(d);
    cw = {e, d};
    mode = $urandom_range(0, 9);
    a = $urandom_range(0, DW + EW - 1);
    if (mode >= 4 && mode <= 8) cw[a] = ~cw[a];
    if (mode >= 7 && mode <= 8) begin
      c = $urandom_range(0, DW + EW - 2);
      if (c >= a) c = c + 1;
      cw[c] = ~cw[c];
    end
    if (mode == 9) cw[DW+EW-1:DW] = 7'($urandom);
    d = cw[DW-1:0];
    e = cw[DW+EW-1:DW];
  endtask

  // ------------------------------------------------------- main sequence
  logic [EW-1:0] e_dead;
  logic [EW-1:0] e_1234;
  logic [DW-1:0] raw0;
  logic          p_sg;
  logic          p_db;
  logic [DW-1:0] p_fx;
  logic [DW-1:0] rd0;
  logic [DW-1:0] rd1;
  logic [EW-1:0] re0;
  logic [EW-1:0] re1;

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    rd_valid = 1'b0;
    rd_addr = '0;
    rd_bank_en = '0;
    rd_data = '0;
    rd_ecc = '0;
    ecc_disable = 1'b0;
    detect_only = 1'b0;
    scrub_ready = 1'b0;
    cnt_clr = 1'b0;

    // Hand-computed pins for the model's encoder and decoder.
    check("pin_enc_1", 64'(m_encode(32'h1)), 64'h43);
    check("pin_enc_2", 64'(m_encode(32'h2)), 64'h45);
    check("pin_enc_msb", 64'(m_encode(32'h8000_0000)), 64'h26);
    m_decode(32'h21, 7'h43, p_sg, p_db, p_fx);
    check("pin_dec_sg", 64'(p_sg), 64'h1);
    check("pin_dec_fx", 64'(p_fx), 64'h1);

    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_scrub_valid", 64'(scrub_valid), 64'h0);
    check("rst_single_cnt", 64'(single_cnt), 64'h0);
    check("rst_overflow", 64'(scrub_overflow), 64'h0);
    @(negedge clk);
    rst = 1'b0;

    e_dead = m_encode(32'hDEAD_BEEF);
    e_1234 = m_encode(32'h1234_5678);

    // Clean read.
    drive_read(16'h0100, 2'b11, 32'hDEAD_BEEF, e_dead, 32'h1234_5678, e_1234);
    check("clean_data", 64'(out_data), 64'h1234_5678_DEAD_BEEF);
    check("clean_flags", 64'({single_err, double_err}), 64'h0);
    check("clean_scrub", 64'(scrub_valid), 64'h0);

    // Single error in bank 1: data 1 with bit 5 flipped.
    drive_read(16'h0200, 2'b11, 32'hDEAD_BEEF, e_dead, 32'h21, 7'h43);
    check("sgl_flags", 64'(single_err), 64'h2);
    check("sgl_data", 64'(out_data[63:32]), 64'h1);
    check("sgl_scrub_valid", 64'(scrub_valid), 64'h1);
    check("sgl_scrub_bank", 64'(scrub_bank), 64'h1);
    check("sgl_scrub_addr", 64'(scrub_addr), 64'h0200);
    check("sgl_scrub_ecc", 64'(scrub_ecc), 64'h43);
    check("sgl_cnt", 64'(single_cnt), 64'h1);

    drive_read(16'h0201, 2'b11, 32'hDEAD_BEEF, e_dead, 32'h1234_5678 ^ 32'h20, e_1234);
    check("sgl2_data", 64'(out_data[63:32]), 64'h1234_5678);
    check("sgl2_cnt", 64'(single_cnt), 64'h2);
    scrub_ready = 1'b1;
    idle(3);
    scrub_ready = 1'b0;
    check("drain_empty", 64'(scrub_valid), 64'h0);

    // Double error in bank 0: bits 3 and 17.
    raw0 = 32'hDEAD_BEEF ^ (32'h1 << 3) ^ (32'h1 << 17);
    drive_read(16'h0300, 2'b01, raw0, e_dead, 32'h0, 7'h0);
    check("dbl_flags", 64'(double_err), 64'h1);
    check("dbl_data", 64'(out_data[31:0]), 64'(raw0));
    check("dbl_no_push", 64'(scrub_valid), 64'h0);
    check("dbl_cnt", 64'(double_cnt), 64'h1);
    ecc_disable = 1'b1;
    drive_read(16'h0300, 2'b01, raw0, e_dead, 32'h0, 7'h0);
    ecc_disable = 1'b0;
    check("dis_flags", 64'({single_err, double_err}), 64'h0);
    check("dis_cnt", 64'(double_cnt), 64'h1);

    // Overflow: five single errors into a four-entry queue.
    cnt_clr = 1'b1;
    idle(1);
    cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) drive_read(16'h0400 + 16'(i), 2'b01, 32'h21, 7'h43, 32'h0, 7'h0);
    check("ovf_flag", 64'(scrub_overflow), 64'h1);
    check("ovf_sat_cnt", 64'(single_cnt), 64'h3);
    scrub_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("ovf_pop_valid", 64'(scrub_valid), 64'h1);
      check("ovf_pop_addr", 64'(scrub_addr), 64'h0400 + 64'(k));
      @(negedge clk);
    end
    check("ovf_drained", 64'(scrub_valid), 64'h0);
    scrub_ready = 1'b0;

    // Clear in the same cycle as a new error.
    cnt_clr = 1'b1;
    drive_read(16'h0480, 2'b01, 32'h21, 7'h43, 32'h0, 7'h0);
    cnt_clr = 1'b0;
    check("clr_cnt", 64'(single_cnt), 64'h0);
    check("clr_ovf", 64'(scrub_overflow), 64'h0);
    scrub_ready = 1'b1;
    idle(2);
    scrub_ready = 1'b0;

    // Reset while two entries are queued and a read is in flight.
    drive_read(16'h0500, 2'b01, 32'h21, 7'h43, 32'h0, 7'h0);
    drive_read(16'h0501, 2'b10, 32'h0, 7'h0, 32'h21, 7'h43);
    check("pre_rst_cnt", 64'(single_cnt), 64'h2);
    rst = 1'b1;
    drive_read(16'h0502, 2'b01, 32'h21, 7'h43, 32'h0, 7'h0);
    rst = 1'b0;
    check("rst_mid_valid", 64'(out_valid), 64'h0);
    check("rst_mid_data", 64'(out_data), 64'h0);
    check("rst_mid_flags", 64'({single_err, double_err}), 64'h0);
    check("rst_mid_scrub", 64'(scrub_valid), 64'h0);
    check("rst_mid_addr", 64'(scrub_addr), 64'h0);
    check("rst_mid_cnt", 64'(single_cnt), 64'h0);

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      make_word(rd0, re0);
      make_word(rd1, re1);
      rd_valid    = ($urandom_range(0, 3) != 0);
      rd_addr     = 16'($urandom);
      rd_bank_en  = 2'($urandom);
      rd_data     = {rd1, rd0};
      rd_ecc      = {re1, re0};
      ecc_disable = ($urandom_range(0, 7) == 0);
      detect_only = ($urandom_range(0, 7) == 0);
      scrub_ready = ($urandom_range(0, 1) == 0);
      cnt_clr     = ($urandom_range(0, 15) == 0);
      rst         = ($urandom_range(0, 63) == 0);
      @(negedge clk);
    end
    rst = 1'b0;
    cnt_clr = 1'b0;
    ecc_disable = 1'b0;
    detect_only = 1'b0;
    idle(2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
